// File: rtl/mem_stage_requester.sv
// Y86-64 memory-stage initiator: decodes one access and runs it over a
// req/ready + rvalid handshake, with range and timeout fault reporting.
module mem_stage_requester #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic [63:0] valM,
    output logic        busy,
    output logic        done,
    output logic        mem_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_R,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [63:0]     valm_q, valm_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            dec_acc;
    logic            dec_we;
    logic [63:0]     dec_addr;
    logic [63:0]     dec_data;
    logic            in_range;
    logic            tmo_hit;

    // Instruction decode into access type, address and write data.
    always_comb begin
        dec_acc  = 1'b0;
        dec_we   = 1'b0;
        dec_addr = 64'd0;
        dec_data = 64'd0;
        case (icode)
            4'h4: begin dec_acc = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_data = valA; end
            4'h5: begin dec_acc = 1'b1; dec_addr = valE; end
            4'h8: begin dec_acc = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_data = valP; end
            4'h9: begin dec_acc = 1'b1; dec_addr = valA; end
            4'hA: begin dec_acc = 1'b1; dec_we = 1'b1; dec_addr = valE; dec_data = valA; end
            4'hB: begin dec_acc = 1'b1; dec_addr = valA; end
            default: ;
        endcase
    end

    assign in_range = dec_addr < 64'(MEM_WORDS);
    assign tmo_hit  = cnt_q == CW'(TIMEOUT - 1);

    // Next-state and datapath updates for the access sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        valm_d  = valm_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    addr_d  = dec_addr;
                    wdata_d = dec_data;
                    we_d    = dec_we;
                    cnt_d   = '0;
                    if (!dec_acc) begin
                        state_d = S_DONE;
                    end else if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT_R;
                    if (!tmo_hit) cnt_d = cnt_q + 1'b1;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    valm_d  = mem_rdata;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            we_q    <= 1'b0;
            valm_q  <= 64'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req   = state_q == S_ISSUE;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign valM      = valm_q;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign mem_error = err_q;

endmodule
